instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program loader. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words using the opcode map the CPU main decoder consumes. It then writes the words sequentially into instruction memory. It sits between the testbench/boot source and imem, and it is the writer side of the op/control decode path.

## Interface
- n, 32, instruction word width
- DEPTH, 64, imem capacity in words; AW = $clog2(DEPTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; clears pointer/flags, begins a load session
- finish  in  1  pulse; ends the session
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_op  in  6  opcode
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate/offset
- in_target  in  26  jump target
- mem_we  out  1  imem write strobe
- mem_addr  out  AW  imem word address
- mem_wdata  out  n  encoded instruction
- count  out  AW+1  words written this session
- err  out  1  sticky: illegal opcode seen
- done  out  1  session complete (level)

## Operation
- Encoding is fixed by opcode class:
  - R-type, op 0x01–0x0B (add, sub, mul, div, or, and, nor, xor, sll, srl, slt): {op, rs, rt, rd, 11'b0}
  - I-type, op 0x10 beq, 0x20 lw, 0x21 sw, 0x22 addi, 0x2B subi: {op, rs, rt, imm}
  - J-type, op 0x30 j, 0x31 jal: {op, target}
  - jr, op 0x33: {op, rs, 21'b0}
  - Any other op (0x00 included) is illegal. Nothing is written, err is set, and count is unchanged.
- FSM states: IDLE, LOAD, WRITE, DONE.
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1.
    - A legal handshake (in_valid&in_ready) latches the encoded word and goes to WRITE.
    - An illegal handshake sets err and stays in LOAD.
    - finish -> DONE. If finish and a handshake occur in the same cycle, finish wins and the bundle is dropped (in_ready is forced 0 that cycle).
  - WRITE: mem_we=1 for exactly this cycle, with mem_addr=wptr and mem_wdata=latched word.
    - wptr and count both increment.
    - Next state is DONE if count+1 == DEPTH, otherwise LOAD.
  - DONE: done=1, in_ready=0. start -> LOAD, clearing wptr, count and err.
- start in any state restarts the session: it goes to LOAD and clears wptr, count and err. A pending WRITE is abandoned and not written.
- wptr never wraps. Full (count==DEPTH) forces DONE.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, done=0.
- Latency: the handshake in cycle t produces mem_we in cycle t+1. in_ready is high again in t+2. Peak throughput is 1 word per 2 cycles.
- Outputs are registered or decoded from the registered state only. No combinational path runs from in_* to mem_*.
- in_ready depends only on state and finish, not on in_valid.
- count is updated on the same edge that ends WRITE, so it is visible in t+2.
- err is asserted from the cycle after the illegal handshake.
- Reset mid-WRITE: no write completes and all outputs return to reset values immediately.

## Test plan
- Reset, then start. Send add rs=1 rt=2 rd=3 -> mem_we at addr 0, wdata 0x04221800. Then send lw rs=4 rt=5 imm=0x0010 -> addr 1, wdata 0x80850010. After these two words, count=2.
- Send j target=0x0000040, then jr rs=31 -> wdata 0xC0000040 at addr 0 and 0xCFE00000 at addr 1. Back-to-back in_valid must yield exactly one accept every 2 cycles.
- Send op 0x3F, then beq rs=1 rt=1 imm=0xFFFF. For 0x3F there is no write and err=1 from the next cycle. The beq then writes 0x4021FFFF at addr 0, count=1, and err stays 1.
- With DEPTH=4, stream 5 legal bundles -> 4 writes at addr 0..3, done=1 after the 4th, in_ready=0, and the 5th is never accepted.
- Assert finish in the same cycle as a valid bundle -> bundle not accepted, no write, done=1. A following start gives count=0, err=0 and in_ready=1.
- Assert rst_n low during WRITE -> mem_we drops immediately and all outputs take their reset values. After release, state is IDLE.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs decoded field bundles into
// 32-bit instruction words and writes them sequentially into imem.
module instr_encoder #(
  parameter int n     = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [n-1:0]  mem_wdata,
  output logic [AW:0]   count,
  output logic          err,
  output logic          done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0] OP_BEQ  = 6'h10;
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_SW   = 6'h21;
  localparam logic [5:0] OP_ADDI = 6'h22;
  localparam logic [5:0] OP_SUBI = 6'h2B;
  localparam logic [5:0] OP_J    = 6'h30;
  localparam logic [5:0] OP_JAL  = 6'h31;
  localparam logic [5:0] OP_JR   = 6'h33;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]    state_reg;
  logic [AW-1:0] wptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          err_reg;
  logic [n-1:0]  word_reg;
  logic [n-1:0]  enc_word;
  logic          enc_legal;

  // Opcode-class packing; anything outside the map is flagged illegal.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    if (in_op inside {[6'h01:6'h0B]}) begin
      enc_word  = n'({in_op, in_rs, in_rt, in_rd, 11'b0});
      enc_legal = 1'b1;
    end else begin
      case (in_op)
        OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_SUBI: begin
          enc_word  = n'({in_op, in_rs, in_rt, in_imm});
          enc_legal = 1'b1;
        end
        OP_J, OP_JAL: begin
          enc_word  = n'({in_op, in_target});
          enc_legal = 1'b1;
        end
        OP_JR: begin
          enc_word  = n'({in_op, in_rs, 21'b0});
          enc_legal = 1'b1;
        end
        default: begin
          enc_word  = '0;
          enc_legal = 1'b0;
        end
      endcase
    end
  end

  assign count_next = count_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      word_reg  <= '0;
    end else if (start) begin
      // Restart from any state; an in-flight WRITE is dropped.
      state_reg <= LOAD;
      wptr_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (finish || count_reg == FULL) begin
            state_reg <= DONE;
          end else if (in_valid) begin
            if (enc_legal) begin
              word_reg  <= enc_word;
              state_reg <= WRITE;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        WRITE: begin
          count_reg <= count_next;
          if (count_next == FULL) begin
            state_reg <= DONE;
          end else begin
            wptr_reg  <= wptr_reg + 1'b1;
            state_reg <= LOAD;
          end
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

  // finish takes priority over a simultaneous bundle, so it masks in_ready.
  assign in_ready  = (state_reg == LOAD) && !finish;
  assign mem_we    = (state_reg == WRITE) && !start;
  assign mem_addr  = wptr_reg;
  assign mem_wdata = word_reg;
  assign count     = count_reg;
  assign err       = err_reg;
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes,
// a negedge monitor pops and compares them against imem write strobes.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, finish, in_valid, in_ready;
  logic [5:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          err, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int t1, t2;
  bit seen_ready;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_e;

  instr_encoder #(.n(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .err(err), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== mon_e) begin
            errors++;
            $display("FAIL write: got addr=%0d data=0x%08h, expected addr=%0d data=0x%08h",
                     mem_addr, mem_wdata, mon_e[AW+31:32], mon_e[31:0]);
          end else begin
            $display("write addr=%0d data=0x%08h", mem_addr, mem_wdata);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Presents a bundle and waits (bounded) for its handshake; in_valid stays
  // high afterwards so consecutive calls stream back-to-back.
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit push, input logic [AW-1:0] ea, input logic [31:0] ed);
    int w;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: op=0x%0h not accepted within 50 cycles", op);
    end else begin
      acc_cyc = cyc;
      if (push) exp_q.push_back({ea, ed});
    end
    step();
  endtask

  task automatic chk_reset_values();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
  endtask

  logic [31:0] fill_data [4] = '{32'h04220000, 32'h04220800, 32'h04221000, 32'h04221800};

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (2) step();
    chk_reset_values();
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 0);

    // add then lw
    pulse_start();
    send(6'h01, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 2'd0, 32'h04221800);
    send(6'h20, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 1, 2'd1, 32'h80850010);
    idle();
    repeat (2) step();
    chk("count_after_two", count, 2);

    // j then jr, streamed back-to-back
    pulse_start();
    chk("count_after_start", count, 0);
    send(6'h30, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1, 2'd0, 32'hC0000040);
    t1 = acc_cyc;
    send(6'h33, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 1, 2'd1, 32'hCFE00000);
    t2 = acc_cyc;
    idle();
    chk("accept_spacing", 64'(t2 - t1), 2);
    repeat (2) step();

    // illegal opcode then beq
    pulse_start();
    chk("err_before_illegal", err, 0);
    send(6'h3F, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 0, 2'd0, 32'h0);
    chk("err_after_illegal", err, 1);
    chk("count_after_illegal", count, 0);
    send(6'h10, 5'd1, 5'd1, 5'd0, 16'hFFFF, 26'h0, 1, 2'd0, 32'h4021FFFF);
    idle();
    repeat (2) step();
    chk("count_after_beq", count, 1);
    chk("err_sticky", err, 1);

    // fill imem to capacity, fifth bundle must never be accepted
    pulse_start();
    for (int i = 0; i < 4; i++)
      send(6'h01, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0, 1, 2'(i), fill_data[i]);
    idle();
    repeat (2) step();
    chk("full_done", done, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    in_op = 6'h01; in_valid = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) seen_ready = 1'b1;
    end
    step();
    idle();
    chk("fifth_not_accepted", seen_ready, 0);
    chk("full_mem_addr_held", mem_addr, 3);

    // finish colliding with a valid bundle
    pulse_start();
    send(6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 0, 2'd0, 32'h0);
    in_op = 6'h01; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    finish = 1'b1;
    @(negedge clk);
    chk("finish_masks_ready", in_ready, 0);
    step();
    finish = 1'b0;
    idle();
    chk("finish_done", done, 1);
    chk("finish_count", count, 0);
    repeat (2) step();
    pulse_start();
    chk("restart_count", count, 0);
    chk("restart_err", err, 0);
    chk("restart_done", done, 0);
    chk("restart_in_ready", in_ready, 1);

    // async reset in the middle of a WRITE cycle
    send(6'h22, 5'd7, 5'd8, 5'd0, 16'h1234, 26'h0, 0, 2'd0, 32'h0);
    idle();
    chk("write_in_progress", mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_values();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_reset_idle_ready", in_ready, 0);
    chk("post_reset_idle_done", done, 0);
    chk("post_reset_no_write", mem_we, 0);

    repeat (2) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
